csr_exe: RTL
============

// Module: csr_exe
// PURPOSE
//  CSR execution unit: sits directly upstream of the csr register file.
//  Accepts one CSR instruction (CSRRW/CSRRS/CSRRC) from issue, waits until it
//  is at ROB head, performs an atomic read-modify-write on the csr file and
//  returns the old value to writeback. One instruction in flight, no overlap.
// PARAMETERS
//  DATA     32  CSR/data width
//  CSR_ADDR 12  CSR address width
//  ROB      5   ROB id width
// PORTS
//  clk          in   1         clock, all state on rising edge
//  reset        in   1         asynchronous, active-high reset
//  in_valid     in   1         issue offers a CSR op
//  in_ready     out  1         unit can accept (state IDLE)
//  in_op        in   2         01 RW, 10 RS, 11 RC, 00 reserved
//  in_addr      in   CSR_ADDR  target CSR
//  in_src       in   DATA      rs1 value or zero-extended uimm
//  in_src_zero  in   1         rs1==x0 / uimm==0 (RS/RC suppress write)
//  in_rob_id    in   ROB       tag returned at writeback
//  commit_ok    in   1         op is at ROB head, may take architectural effect
//  flush        in   1         pipeline flush (mispredict/trap)
//  csr_rd_addr  out  CSR_ADDR  read address to csr file (combinational read)
//  csr_rd_data  in   DATA      read data, same cycle
//  csr_rd_err   in   1         address unimplemented / privilege fault
//  csr_we       out  1         single-cycle write strobe
//  csr_wr_addr  out  CSR_ADDR  write address
//  csr_wr_data  out  DATA      write data
//  wb_valid     out  1         result available
//  wb_ready     in   1         writeback accepts result
//  wb_data      out  DATA      old CSR value (0 on exception)
//  wb_rob_id    out  ROB       tag of completed op
//  wb_exc       out  1         illegal-instruction exception
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; csr_we=0; wb_valid=0; wb_exc=0; all
//   data/addr/id registers 0. Reset mid-operation drops the op, no write.
//  States: IDLE -> WAIT -> READ -> (WRITE) -> RESP -> IDLE.
//  IDLE: in_ready=1; in_valid latches op/addr/src/src_zero/rob_id -> WAIT.
//  WAIT: commit_ok -> READ; flush -> IDLE (flush wins over commit_ok).
//  READ: csr_rd_addr=latched addr (driven from register in every state);
//   capture old=csr_rd_data, err=csr_rd_err|(op==00).
//   err -> RESP, wb_exc=1, wb_data=0, no write.
//   else need_wr = (op==RW) | !src_zero; need_wr -> WRITE, else RESP.
//   flush in READ -> IDLE, nothing captured.
//  WRITE: csr_we=1 exactly one cycle; csr_wr_addr=addr;
//   RW: wr=src; RS: wr=old|src; RC: wr=old&~src (full DATA width) -> RESP.
//  RESP: wb_valid=1, wb_data=old, wb_rob_id, wb_exc held stable until
//   wb_ready sampled high -> IDLE (wb_valid low next cycle).
//  flush ignored in WRITE and RESP (op already committed).
//  Latency: commit_ok seen in WAIT at cycle N -> READ N+1, csr_we N+2,
//   wb_valid N+3 (N+2 when no write or exception).
//  in_ready low in all states except IDLE; no accept same cycle as RESP exit.
//  RW with rd=x0 still writes; read side effects are not modelled here.
// TESTING
//  RW addr 0x340 src 0xDEAD_BEEF, CSR holds 0x1234 -> one csr_we with
//   0xDEAD_BEEF, wb_data=0x1234, wb_valid at commit+3.
//  RS src 0x0F, src_zero=1, CSR 0xF0 -> no csr_we, wb_data=0xF0 at commit+2;
//   RC src 0x30, CSR 0xF0 -> csr_we data 0xC0.
//  csr_rd_err=1 on READ (addr 0x7FF) -> no csr_we, wb_exc=1, wb_data=0.
//  flush asserted in WAIT with commit_ok=1 same cycle -> no csr_we,
//   no wb_valid, in_ready=1 next cycle.
//  wb_ready low 5 cycles in RESP -> wb_valid/wb_data/wb_rob_id stable,
//   in_ready low until cycle after wb_ready=1.
//  reset pulsed in WRITE-pending READ -> csr_we never asserts, outputs at
//   reset values, next op completes normally.

Source files
------------

// File: rtl/csr_exe.sv
// CSR execution unit. Holds a single CSR instruction until it reaches the ROB
// head, then does one atomic read-modify-write on the CSR file and returns
// the old value (or an illegal-instruction exception) to writeback.
module csr_exe #(
  parameter int DATA     = 32,
  parameter int CSR_ADDR = 12,
  parameter int ROB      = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [CSR_ADDR-1:0] in_addr,
  input  logic [DATA-1:0]     in_src,
  input  logic                in_src_zero,
  input  logic [ROB-1:0]      in_rob_id,
  input  logic                commit_ok,
  input  logic                flush,
  output logic [CSR_ADDR-1:0] csr_rd_addr,
  input  logic [DATA-1:0]     csr_rd_data,
  input  logic                csr_rd_err,
  output logic                csr_we,
  output logic [CSR_ADDR-1:0] csr_wr_addr,
  output logic [DATA-1:0]     csr_wr_data,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [DATA-1:0]     wb_data,
  output logic [ROB-1:0]      wb_rob_id,
  output logic                wb_exc
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  logic [2:0]          state;
  logic [1:0]          op_q;
  logic [CSR_ADDR-1:0] addr_q;
  logic [DATA-1:0]     src_q;
  logic                src_zero_q;
  logic [ROB-1:0]      rob_q;
  logic [DATA-1:0]     old_q;
  logic                exc_q;

  logic                rd_fault;
  logic                need_wr;

  // New CSR value from the captured old value and the source operand.
  function automatic logic [DATA-1:0] rmw_data(input logic [1:0]      op,
                                               input logic [DATA-1:0] old,
                                               input logic [DATA-1:0] src);
    logic [DATA-1:0] res;
    case (op)
      OP_RW:   res = src;
      OP_RS:   res = old | src;
      OP_RC:   res = old & ~src;
      default: res = old;
    endcase
    return res;
  endfunction

  // Fault and write-needed decisions made while the CSR file is being read.
  // RS/RC with a zero operand must not write (no side effects on read-only CSRs).
  always_comb begin
    rd_fault = csr_rd_err | (op_q == 2'b00);
    need_wr  = (op_q == OP_RW) | ~src_zero_q;
  end

  // Sequencer and operand/result registers; a reset drops any op in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      rob_q      <= '0;
      old_q      <= '0;
      exc_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q       <= in_op;
            addr_q     <= in_addr;
            src_q      <= in_src;
            src_zero_q <= in_src_zero;
            rob_q      <= in_rob_id;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush)          state <= S_IDLE;
          else if (commit_ok) state <= S_READ;
        end
        S_READ: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (rd_fault) begin
            old_q <= '0;
            exc_q <= 1'b1;
            state <= S_RESP;
          end else begin
            old_q <= csr_rd_data;
            exc_q <= 1'b0;
            state <= need_wr ? S_WRITE : S_RESP;
          end
        end
        S_WRITE: state <= S_RESP;
        S_RESP: begin
          if (wb_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state and driven straight from the held registers.
  always_comb begin
    in_ready    = (state == S_IDLE);
    csr_rd_addr = addr_q;
    csr_we      = (state == S_WRITE);
    csr_wr_addr = addr_q;
    csr_wr_data = rmw_data(op_q, old_q, src_q);
    wb_valid    = (state == S_RESP);
    wb_data     = old_q;
    wb_rob_id   = rob_q;
    wb_exc      = exc_q & (state == S_RESP);
  end

endmodule
